// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package disp_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Digit 0 lives in the most significant nibble, so the nibble slot is
  // the bit-inverse of the digit index.
  function automatic logic [3:0] digit_nibble(input logic [31:0] dat,
                                              input logic [2:0]  idx);
    return dat[{~idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Hex nibble to 7-segment pattern lookup (dp bit is added by the caller).
// Latency: combinational.
// Backpressure: none.
// Ports: nib - hex digit in; pat - active-high {g..a} pattern out.
module hex7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = HEX7[nib];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with per-slot blanking and
// frame-aligned double-buffered display data. Latency: all outputs registered;
// a load shows from the next frame start. Backpressure: none, last load wins.
// Ports: clk/rst_n (async low); en scan enable; load + data_in/dp_in new
// display contents; count digit index; seg {dp,g..a}; load_ack when a load
// is applied; frame_done at the end of the count-7 slot.
module seg_scan_driver
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000, // cycles per digit slot, > BLANK_CYC
  parameter int BLANK_CYC = 16,   // blanked cycles at slot start, >= 1
  parameter int TW        = 16    // timer width, 2**TW > SCAN_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  output logic [2:0]  count,
  output logic [7:0]  seg,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int SHOW_CYC = SCAN_DIV - BLANK_CYC;
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_CYC - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [7:0]    seg_q, seg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   shadow_dat_q, shadow_dat_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d;
  logic [31:0]   pend_dat_q, pend_dat_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          pend_vld_q, pend_vld_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_done_q, frame_done_d;

  logic          apply;
  logic [6:0]    hex_pat;
  logic [7:0]    show_pat;

  hex7_decode u_hex7 (
    .nib (digit_nibble(shadow_dat_q, count_q)),
    .pat (hex_pat)
  );

  // dp bit 7 belongs to digit 0, hence the inverted index.
  assign show_pat = {shadow_dp_q[~count_q], hex_pat};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    seg_d        = seg_q;
    timer_d      = timer_q;
    shadow_dat_d = shadow_dat_q;
    shadow_dp_d  = shadow_dp_q;
    pend_dat_d   = pend_dat_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    apply        = 1'b0;

    if (load) begin
      pend_dat_d = data_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end

    if (!en) begin
      // Disable parks the scanner but keeps any pending load for later.
      state_d = IDLE;
      count_d = 3'd0;
      seg_d   = 8'h00;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          count_d = 3'd0;
          seg_d   = 8'h00;
          timer_d = '0;
          apply   = 1'b1;
        end
        BLANK: begin
          seg_d = 8'h00;
          if (timer_q == BLANK_LAST) begin
            // Pattern is loaded on the same edge the state enters SHOW.
            state_d = SHOW;
            timer_d = '0;
            seg_d   = show_pat;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        SHOW: begin
          seg_d = show_pat;
          if (timer_q == SHOW_LAST) begin
            state_d = BLANK;
            timer_d = '0;
            seg_d   = 8'h00;
            count_d = count_q + 3'd1;
            if (count_q == LAST_DIGIT) begin
              frame_done_d = 1'b1;
              apply        = 1'b1;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          count_d = 3'd0;
          seg_d   = 8'h00;
          timer_d = '0;
        end
      endcase
    end

    // Frame start: a load arriving in the same cycle bypasses the pending copy.
    if (apply) begin
      if (load) begin
        shadow_dat_d = data_in;
        shadow_dp_d  = dp_in;
        pend_vld_d   = 1'b0;
        load_ack_d   = 1'b1;
      end else if (pend_vld_q) begin
        shadow_dat_d = pend_dat_q;
        shadow_dp_d  = pend_dp_q;
        pend_vld_d   = 1'b0;
        load_ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= 3'd0;
      seg_q        <= 8'h00;
      timer_q      <= '0;
      shadow_dat_q <= 32'h0;
      shadow_dp_q  <= 8'h00;
      pend_dat_q   <= 32'h0;
      pend_dp_q    <= 8'h00;
      pend_vld_q   <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      seg_q        <= seg_d;
      timer_q      <= timer_d;
      shadow_dat_q <= shadow_dat_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_dat_q   <= pend_dat_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign count      = count_q;
  assign seg        = seg_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with short slots (8 cycles, 2 blanked).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int SHOW_CYC  = SCAN_DIV - BLANK_CYC;
  localparam int LIMIT     = 300;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [2:0]  count;
  logic [7:0]  seg;
  logic        load_ack;
  logic        frame_done;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .TW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .count      (count),
    .seg        (seg),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cnt;
    logic [7:0] seg;
    bit         chk_blank;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   ack_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: one scoreboard entry per completed lit run of seg.
  int         cyc = 0;
  logic [7:0] prev_seg = 8'h00;
  logic [2:0] prev_count = 3'd0;
  int         zrun = 0;
  logic [2:0] run_cnt = 3'd0;
  logic [7:0] run_seg = 8'h00;
  int         run_len = 0;
  bit         run_stable = 1'b0;
  int         run_blank = 0;
  exp_t       e;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (seg != 8'h00) begin
      if (prev_seg == 8'h00) begin
        run_cnt    = count;
        run_seg    = seg;
        run_len    = 1;
        run_stable = 1'b1;
        run_blank  = zrun;
      end else begin
        run_len = run_len + 1;
        if (seg !== run_seg) run_stable = 1'b0;
      end
    end else begin
      if (prev_seg != 8'h00 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (run_cnt !== e.cnt) begin
          bad++;
          $display("FAIL sb_count: got %0d expected %0d", run_cnt, e.cnt);
        end
        total++;
        if (run_seg !== e.seg) begin
          bad++;
          $display("FAIL sb_seg: count %0d got %h expected %h", e.cnt, run_seg, e.seg);
        end
        total++;
        if (run_len != SHOW_CYC || !run_stable) begin
          bad++;
          $display("FAIL sb_show_len: count %0d got len %0d stable %0d expected len %0d stable 1",
                   e.cnt, run_len, run_stable, SHOW_CYC);
        end
        if (e.chk_blank) begin
          total++;
          if (run_blank != BLANK_CYC) begin
            bad++;
            $display("FAIL sb_blank: count %0d got %0d blank cycles expected %0d",
                     e.cnt, run_blank, BLANK_CYC);
          end
        end
      end
      zrun = (count != prev_count) ? 1 : zrun + 1;
    end
    prev_seg   = seg;
    prev_count = count;
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (load_ack === 1'b1) ack_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_show(input logic [2:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      step();
      if (count === c && seg !== 8'h00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      step();
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      step();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] s, input bit cb);
    exp_t x;
    x.cnt = c;
    x.seg = s;
    x.chk_blank = cb;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = 32'h0; dp_in = 8'h00;
    #3;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d expected 0", count); end
    total++; if (seg !== 8'h00) begin bad++; $display("FAIL rst_seg: got %h expected 00", seg); end
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL rst_load_ack: got %b expected 0", load_ack); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    step();
    step();
    rst_n = 1'b1;
    step();
    total++; if (seg !== 8'h00 || count !== 3'd0) begin
      bad++; $display("FAIL idle_disabled: got count %0d seg %h expected 0 00", count, seg);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pat [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    bit ok;
    data_in = 32'h0123_4567; dp_in = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL basic_no_ack_idle: got %b expected 0", load_ack); end
    fd_q.delete(); ack_q.delete();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 8; d++) push(3'(d), pat[d], !(f == 0 && d == 0));
    en = 1'b1;
    step();
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL basic_ack_start: got %b expected 1", load_ack); end
    total++; if (seg !== 8'h00 || count !== 3'd0) begin
      bad++; $display("FAIL basic_first_blank: got count %0d seg %h expected 0 00", count, seg);
    end
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: %0d entries left expected 0", exp_q.size()); end
    total++; if (fd_q.size() != 2 || fd_q[1] - fd_q[0] != 8 * SCAN_DIV) begin
      bad++; $display("FAIL basic_frame_period: got %0d pulses expected 2 spaced %0d", fd_q.size(), 8 * SCAN_DIV);
    end
    total++; if (ack_q.size() != 1) begin bad++; $display("FAIL basic_ack_count: got %0d expected 1", ack_q.size()); end
  endtask

  task automatic test_midframe_load();
    logic [7:0] old_pat [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    bit ok;
    wait_show(3'd3, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_wait: got timeout expected count 3 lit"); end
    data_in = 32'hFFFF_FFFF; load = 1'b1;
    step();
    load = 1'b0;
    fd_q.delete(); ack_q.delete();
    for (int d = 3; d < 8; d++) push(3'(d), old_pat[d], 1'b1);
    for (int d = 0; d < 8; d++) push(3'(d), 8'h71, 1'b1);
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout: %0d entries left expected 0", exp_q.size()); end
    total++; if (ack_q.size() != 1 || fd_q.size() != 2) begin
      bad++; $display("FAIL mid_pulses: got acks %0d frames %0d expected 1 2", ack_q.size(), fd_q.size());
    end else begin
      total++; if (ack_q[0] != fd_q[0]) begin
        bad++; $display("FAIL mid_ack_at_boundary: got ack cyc %0d expected %0d", ack_q[0], fd_q[0]);
      end
    end
  endtask

  task automatic test_two_loads();
    bit ok;
    ack_q.delete();
    wait_show(3'd2, ok);
    total++; if (!ok) begin bad++; $display("FAIL two_wait_a: got timeout expected count 2 lit"); end
    data_in = 32'hAAAA_AAAA; load = 1'b1;
    step();
    load = 1'b0;
    wait_show(3'd5, ok);
    total++; if (!ok) begin bad++; $display("FAIL two_wait_b: got timeout expected count 5 lit"); end
    data_in = 32'h8888_8888; load = 1'b1;
    step();
    load = 1'b0;
    for (int d = 5; d < 8; d++) push(3'(d), 8'h71, 1'b1);
    for (int d = 0; d < 8; d++) push(3'(d), 8'h7F, 1'b1);
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL two_timeout: %0d entries left expected 0", exp_q.size()); end
    total++; if (ack_q.size() != 1) begin bad++; $display("FAIL two_ack_count: got %0d expected 1", ack_q.size()); end
  endtask

  task automatic test_bypass();
    bit ok;
    wait_show(3'd7, ok);
    total++; if (!ok) begin bad++; $display("FAIL byp_wait: got timeout expected count 7 lit"); end
    for (int i = 0; i < SHOW_CYC - 1; i++) step();
    data_in = 32'h0000_0000; dp_in = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    total++; if (count !== 3'd0 || load_ack !== 1'b1 || frame_done !== 1'b1) begin
      bad++; $display("FAIL byp_same_edge: got count %0d ack %b fd %b expected 0 1 1", count, load_ack, frame_done);
    end
    step();
    for (int d = 0; d < 8; d++) push(3'(d), 8'h3F, 1'b1);
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL byp_timeout: %0d entries left expected 0", exp_q.size()); end
  endtask

  task automatic test_dp();
    bit ok;
    wait_show(3'd4, ok);
    total++; if (!ok) begin bad++; $display("FAIL dp_wait: got timeout expected count 4 lit"); end
    data_in = 32'h0; dp_in = 8'h80; load = 1'b1;
    step();
    load = 1'b0;
    wait_fd(ok);
    total++; if (!ok) begin bad++; $display("FAIL dp_frame_wait: got timeout expected frame_done"); end
    step();
    push(3'd0, 8'hBF, 1'b1);
    for (int d = 1; d < 8; d++) push(3'(d), 8'h3F, 1'b1);
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL dp_timeout: %0d entries left expected 0", exp_q.size()); end
  endtask

  task automatic test_en_drop_reset();
    bit ok;
    wait_show(3'd5, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_wait: got timeout expected count 5 lit"); end
    data_in = 32'h2222_2222; dp_in = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    step();
    en = 1'b0;
    step();
    total++; if (count !== 3'd0 || seg !== 8'h00) begin
      bad++; $display("FAIL drop_next_cycle: got count %0d seg %h expected 0 00", count, seg);
    end
    total++; if (load_ack !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL drop_pulses: got ack %b fd %b expected 0 0", load_ack, frame_done);
    end
    for (int i = 0; i < 3; i++) step();
    total++; if (seg !== 8'h00) begin bad++; $display("FAIL drop_stays_idle: got seg %h expected 00", seg); end
    en = 1'b1;
    step();
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL drop_pending_kept: got ack %b expected 1", load_ack); end
    push(3'd0, 8'h5B, 1'b0);
    data_in = 32'h9999_9999; load = 1'b1;
    step();
    load = 1'b0;
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_timeout: %0d entries left expected 0", exp_q.size()); end
    total++; if (count !== 3'd1 || seg !== 8'h00) begin
      bad++; $display("FAIL pre_reset_blank: got count %0d seg %h expected 1 00", count, seg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0 || seg !== 8'h00 || load_ack !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL async_reset: got count %0d seg %h ack %b fd %b expected 0 00 0 0",
                      count, seg, load_ack, frame_done);
    end
    en = 1'b0;
    step();
    rst_n = 1'b1;
    en = 1'b1;
    step();
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_drops_pending: got ack %b expected 0", load_ack); end
    push(3'd0, 8'h3F, 1'b0);
    wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL reset_timeout: %0d entries left expected 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_midframe_load();
    test_two_loads();
    test_bypass();
    test_dp();
    test_en_drop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
